delay_ctrl_mfic: RTL and testbench

Runtime-programmable delay controller for the sample-delay datapath of the MFIC chain.
- Replaces the fixed-depth shift line with a circular register buffer.
- Sequences fill/run phases whenever the delay is (re)programmed or flushed.
- Qualifies the output with a valid strobe, so downstream logic never consumes stale or reset samples.
- Delay is counted in accepted samples (din_vld strobes), not clocks.

---
 rtl/delay_mfic_pkg.sv | 24 ++
 rtl/delay_ram_mfic.sv | 27 ++
 rtl/delay_ctrl_mfic.sv | 98 +++++++++
 tb/tb_delay_ctrl_mfic.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/delay_mfic_pkg.sv
// Shared types, default constants and the delay-clamp helpers
// for the MFIC sample-delay controller.
package delay_mfic_pkg;

  localparam int unsigned MFIC_DMAX  = 16;
  localparam int unsigned MFIC_D_DEF = 10;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Requested delay forced into 1..dmax.
  function automatic int unsigned clamp_delay(input int unsigned req, input int unsigned dmax);
    if (req == 0)    return 1;
    if (req > dmax)  return dmax;
    return req;
  endfunction

  function automatic logic delay_oob(input int unsigned req, input int unsigned dmax);
    return (req == 0) || (req > dmax);
  endfunction

endpackage

// File: rtl/delay_ram_mfic.sv
// W x DEPTH register array: one gated write port, one registered read port.
// Contents and read register are not reset; the controller masks them.
module delay_ram_mfic
  import delay_mfic_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = MFIC_DMAX,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Read sees the pre-write contents when raddr == waddr.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/delay_ctrl_mfic.sv
// Runtime-programmable sample delay: circular buffer plus FILL/RUN sequencing
// that qualifies dout with dout_vld only once the buffer holds `delay` samples.
module delay_ctrl_mfic
  import delay_mfic_pkg::*;
#(
  parameter  int unsigned W     = 16,
  parameter  int unsigned DMAX  = MFIC_DMAX,
  parameter  int unsigned D_DEF = MFIC_D_DEF,
  localparam int unsigned AW    = $clog2(DMAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  din,
  input  logic          din_vld,
  input  logic [AW:0]   cfg_delay,
  input  logic          cfg_load,
  input  logic          flush,
  output logic          cfg_err,
  output logic          busy,
  output logic [W-1:0]  dout,
  output logic          dout_vld
);

  state_e        state, state_nxt;
  logic [AW:0]   delay, delay_nxt;
  logic [AW:0]   fill_cnt, fill_nxt;
  logic [AW-1:0] wp;
  logic          err_nxt, vld_nxt, busy_nxt;
  logic          rd_seen;
  logic          restart;
  logic          re;
  logic [AW-1:0] raddr;
  logic [W-1:0]  rdata;

  assign restart = cfg_load | flush;
  assign re      = din_vld & ~restart;
  assign raddr   = wp - delay[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FILL;
      delay    <= (AW+1)'(D_DEF);
      fill_cnt <= '0;
      wp       <= '0;
      cfg_err  <= 1'b0;
      busy     <= 1'b1;
      dout_vld <= 1'b0;
      rd_seen  <= 1'b0;
    end else begin
      state    <= state_nxt;
      delay    <= delay_nxt;
      fill_cnt <= fill_nxt;
      cfg_err  <= err_nxt;
      busy     <= busy_nxt;
      dout_vld <= vld_nxt;
      if (din_vld) wp <= wp + AW'(1);
      if (re)      rd_seen <= 1'b1;
    end
  end

  // A restart strobe wins over a coincident sample, which becomes sample #1 of the new fill.
  always_comb begin
    state_nxt = state;
    delay_nxt = delay;
    fill_nxt  = fill_cnt;
    err_nxt   = 1'b0;
    vld_nxt   = 1'b0;
    if (restart) begin
      if (cfg_load) begin
        delay_nxt = (AW+1)'(clamp_delay(32'(cfg_delay), DMAX));
        err_nxt   = delay_oob(32'(cfg_delay), DMAX);
      end
      state_nxt = FILL;
      fill_nxt  = din_vld ? (AW+1)'(1) : '0;
    end else if (din_vld) begin
      vld_nxt = (state == RUN) || (fill_cnt == delay);
      if (state == FILL) begin
        fill_nxt = fill_cnt + (AW+1)'(1);
        if (fill_cnt >= delay - (AW+1)'(1)) state_nxt = RUN;
      end
    end
    busy_nxt = (state_nxt == FILL);
  end

  delay_ram_mfic #(.W(W), .DEPTH(DMAX), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (din_vld),
    .waddr (wp),
    .wdata (din),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  // The RAM read register has no reset; hold dout at zero until its first read.
  assign dout = rd_seen ? rdata : '0;

endmodule

// File: tb/tb_delay_ctrl_mfic.sv
// Self-checking bench for delay_ctrl_mfic: directed scenarios plus random traffic
// compared against a sample-history reference model.
module tb_delay_ctrl_mfic;

  localparam int unsigned W     = 16;
  localparam int unsigned DMAX  = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned D_DEF = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  din;
  logic          din_vld;
  logic [AW:0]   cfg_delay;
  logic          cfg_load;
  logic          flush;
  logic          cfg_err;
  logic          busy;
  logic [W-1:0]  dout;
  logic          dout_vld;

  always #5 clk = ~clk;

  delay_ctrl_mfic #(.W(W), .DMAX(DMAX), .D_DEF(D_DEF)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_vld   (din_vld),
    .cfg_delay (cfg_delay),
    .cfg_load  (cfg_load),
    .flush     (flush),
    .cfg_err   (cfg_err),
    .busy      (busy),
    .dout      (dout),
    .dout_vld  (dout_vld)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: every accepted sample in order, samples stored since restart.
  logic [W-1:0] hist [$];
  int           m_d;
  int           m_n;
  bit           m_vld;
  bit           m_busy;
  bit           m_err;
  logic [W-1:0] m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_d    = D_DEF;
    m_n    = 0;
    m_vld  = 0;
    m_busy = 1;
    m_err  = 0;
    m_dout = '0;
  endtask

  task automatic step(input bit v, input logic [W-1:0] d, input bit ld, input bit fl,
                      input logic [AW:0] cd);
    int req;
    din_vld = v; din = d; cfg_load = ld; flush = fl; cfg_delay = cd;
    req   = int'(cd);
    m_vld = 0;
    m_err = 0;
    if (ld || fl) begin
      if (ld) begin
        m_err = (req == 0) || (req > DMAX);
        m_d   = (req == 0) ? 1 : (req > DMAX) ? DMAX : req;
      end
      m_n    = 0;
      m_busy = 1;
      if (v) begin
        hist.push_back(d);
        m_n = 1;
      end
    end else if (v) begin
      if (m_n >= m_d) begin
        m_vld  = 1;
        m_dout = hist[hist.size() - m_d];
      end
      hist.push_back(d);
      m_n++;
      m_busy = (m_n < m_d);
    end
    @(posedge clk);
    #1;
    check("dout_vld", 32'(dout_vld), 32'(m_vld));
    check("busy", 32'(busy), 32'(m_busy));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
    if (m_vld) check("dout", 32'(dout), 32'(m_dout));
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic push(input logic [W-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, '0);
  endtask

  task automatic load(input logic [AW:0] cd);
    step(1'b0, '0, 1'b1, 1'b0, cd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; din = '0; din_vld = 1'b0; cfg_delay = '0; cfg_load = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_vld", 32'(dout_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b0;

    // Default delay: first valid carries 1 after 11 is accepted.
    for (int i = 1; i <= 14; i++) push(W'(i));

    // Reprogram to 3.
    load(5'd3);
    for (int i = 10; i <= 14; i++) push(W'(i));

    // Gaps at delay 2.
    load(5'd2);
    push(16'hA0A0); idle(); idle(); push(16'hB0B0); push(16'hC0C0); idle();
    check("gap_hold", 32'(dout), 32'h0000A0A0);

    // Clamp low, clamp high and wrap at the maximum delay.
    load(5'd0);
    for (int i = 0; i < 4; i++) push(W'(16'h100 + i));
    load(5'(DMAX + 1));
    for (int i = 0; i < 40; i++) push(W'(16'h200 + i));
    load(5'(DMAX));
    for (int i = 0; i < 20; i++) push(W'(16'h300 + i));

    // Flush colliding with a sample while running.
    load(5'd4);
    for (int i = 0; i < 8; i++) push(W'(16'h400 + i));
    step(1'b1, 16'h0055, 1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) push(W'(16'h500 + i));

    // Load and flush together: load wins.
    step(1'b1, 16'h0077, 1'b1, 1'b1, 5'd1);
    for (int i = 0; i < 3; i++) push(W'(16'h600 + i));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit v, ld, fl;
      v  = ($urandom_range(99, 0) < 75);
      ld = ($urandom_range(99, 0) < 3);
      fl = ($urandom_range(99, 0) < 3);
      step(v, W'($urandom), ld, fl, 5'($urandom_range(DMAX + 3, 0)));
    end

    // Asynchronous reset while output is valid.
    load(5'd3);
    for (int i = 0; i < 10 && !m_vld; i++) push(W'(16'h700 + i));
    check("pre_rst_vld", 32'(dout_vld), 32'd1);
    reset = 1'b1;
    #1;
    check("async_dout", 32'(dout), 32'd0);
    check("async_dout_vld", 32'(dout_vld), 32'd0);
    check("async_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < int'(D_DEF) + 4; i++) push(W'(16'h800 + i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
